l2_port_arbiter: RTL and testbench

//  Shares one 64-bit single-port L2 memory cut pair among N_PORTS requesters.
//  - Round-robin arbitration; one access per cycle; 1-cycle response latency.
//  - Optional zero-fill sweep of the whole array after reset, before serving traffic.
//  - Sits between the SoC L2 interconnect ports and the l2_generic memory wrapper.

---
 rtl/l2_arb_pkg.sv | 22 ++
 rtl/l2_rr_arbiter.sv | 34 +++
 rtl/l2_port_arbiter.sv | 128 ++++++++++++
 tb/tb_l2_port_arbiter.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/l2_arb_pkg.sv
// Shared types for the L2 port arbiter: data/byte-enable widths, FSM states, request bundle.
// Combinational types only; no latency or backpressure of its own.
package l2_arb_pkg;

    localparam int L2_DATA_WIDTH     = 64;
    localparam int L2_BE_WIDTH       = 8;
    // Request bundles carry a fixed-width address; the top keeps only MEM_ADDR_WIDTH bits.
    localparam int L2_MAX_ADDR_WIDTH = 32;

    typedef enum logic {
        INIT,
        RUN
    } l2_state_e;

    typedef struct packed {
        logic                         wen;
        logic [L2_MAX_ADDR_WIDTH-1:0] addr;
        logic [L2_DATA_WIDTH-1:0]     wdata;
        logic [L2_BE_WIDTH-1:0]       be;
    } l2_req_t;

endpackage

// File: rtl/l2_rr_arbiter.sv
// Round-robin pick: first requester at or above ptr, wrapping; one-hot grant plus index.
// Purely combinational, zero latency; no backpressure, the pointer register lives in the parent.
module l2_rr_arbiter #(
    parameter int N_PORTS = 4,
    parameter int PW      = $clog2(N_PORTS)
) (
    input  logic [N_PORTS-1:0] req,
    input  logic [PW-1:0]      ptr,
    output logic [N_PORTS-1:0] gnt,
    output logic [PW-1:0]      idx,
    output logic               any
);

    function automatic logic [PW-1:0] rr_index(input logic [PW-1:0] base, input int offset);
        int s;
        s = int'(base) + offset;
        if (s >= N_PORTS) s = s - N_PORTS;
        return PW'(s);
    endfunction

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (!any && req[rr_index(ptr, i)]) begin
                any = 1'b1;
                idx = rr_index(ptr, i);
            end
        end
        if (any) gnt[idx] = 1'b1;
    end

endmodule

// File: rtl/l2_port_arbiter.sv
// Shares one single-port 64-bit L2 cut among N_PORTS requesters, with optional zero-fill after reset.
// Grant same cycle, response one cycle later; a requester is stalled (no gnt) until its turn or the sweep ends.
module l2_port_arbiter
    import l2_arb_pkg::*;
#(
    parameter int N_PORTS        = 4,
    parameter int MEM_ADDR_WIDTH = 13,
    parameter bit INIT_ON_RESET  = 1'b1
) (
    input  logic                                CLK,
    input  logic                                RSTN,
    input  logic [N_PORTS-1:0]                  req_i,
    output logic [N_PORTS-1:0]                  gnt_o,
    input  logic [N_PORTS-1:0]                  wen_i,
    input  logic [N_PORTS*MEM_ADDR_WIDTH-1:0]   addr_i,
    input  logic [N_PORTS*L2_DATA_WIDTH-1:0]    wdata_i,
    input  logic [N_PORTS*L2_BE_WIDTH-1:0]      be_i,
    output logic [N_PORTS-1:0]                  r_valid_o,
    output logic [L2_DATA_WIDTH-1:0]            r_rdata_o,
    output logic                                init_done_o,
    output logic                                mem_cen_o,
    output logic                                mem_wen_o,
    output logic [MEM_ADDR_WIDTH-1:0]           mem_a_o,
    output logic [L2_DATA_WIDTH-1:0]            mem_d_o,
    output logic [L2_BE_WIDTH-1:0]              mem_be_o,
    input  logic [L2_DATA_WIDTH-1:0]            mem_q_i
);

    localparam int PW = $clog2(N_PORTS);
    localparam logic [MEM_ADDR_WIDTH-1:0] LAST_ADDR = '1;

    l2_state_e                 state, state_nxt;
    logic [MEM_ADDR_WIDTH-1:0] cnt, cnt_nxt;
    logic [PW-1:0]             rr_ptr, rr_ptr_nxt;
    logic [PW-1:0]             arb_idx, rsp_idx;
    logic [N_PORTS-1:0]        arb_gnt;
    logic                      arb_any, grant, rsp_vld;
    l2_req_t                   port_req [N_PORTS];
    l2_req_t                   win;
    logic                      unused_addr_bits;

    always_comb begin
        for (int p = 0; p < N_PORTS; p++) begin
            port_req[p].wen   = wen_i[p];
            port_req[p].addr  = L2_MAX_ADDR_WIDTH'(addr_i[p*MEM_ADDR_WIDTH +: MEM_ADDR_WIDTH]);
            port_req[p].wdata = wdata_i[p*L2_DATA_WIDTH +: L2_DATA_WIDTH];
            port_req[p].be    = be_i[p*L2_BE_WIDTH +: L2_BE_WIDTH];
        end
    end

    l2_rr_arbiter #(
        .N_PORTS (N_PORTS),
        .PW      (PW)
    ) u_rr_arbiter (
        .req (req_i),
        .ptr (rr_ptr),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .any (arb_any)
    );

    assign win              = port_req[arb_idx];
    assign unused_addr_bits = ^win.addr[L2_MAX_ADDR_WIDTH-1:MEM_ADDR_WIDTH];

    // Outputs are forced idle while RSTN is low so the macro sees no access during reset.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        rr_ptr_nxt = rr_ptr;
        grant      = 1'b0;
        gnt_o      = '0;
        mem_cen_o  = 1'b1;
        mem_wen_o  = 1'b1;
        mem_a_o    = '0;
        mem_d_o    = '0;
        mem_be_o   = '0;
        if (RSTN) begin
            unique case (state)
                INIT: begin
                    mem_cen_o = 1'b0;
                    mem_wen_o = 1'b0;
                    mem_be_o  = '1;
                    mem_a_o   = cnt;
                    if (cnt == LAST_ADDR) state_nxt = RUN;
                    else                  cnt_nxt   = cnt + 1'b1;
                end
                RUN: begin
                    if (arb_any) begin
                        grant      = 1'b1;
                        gnt_o      = arb_gnt;
                        mem_cen_o  = 1'b0;
                        mem_wen_o  = win.wen;
                        mem_a_o    = win.addr[MEM_ADDR_WIDTH-1:0];
                        mem_d_o    = win.wdata;
                        mem_be_o   = win.be;
                        rr_ptr_nxt = (arb_idx == PW'(N_PORTS - 1)) ? '0 : arb_idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state   <= INIT_ON_RESET ? INIT : RUN;
            cnt     <= '0;
            rr_ptr  <= '0;
            rsp_vld <= 1'b0;
            rsp_idx <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            rr_ptr  <= rr_ptr_nxt;
            rsp_vld <= grant;
            if (grant) rsp_idx <= arb_idx;
        end
    end

    always_comb begin
        r_valid_o = '0;
        if (rsp_vld) r_valid_o[rsp_idx] = 1'b1;
    end

    assign r_rdata_o   = mem_q_i;
    assign init_done_o = (state == RUN);

endmodule

// File: tb/tb_l2_port_arbiter.sv
// Bench for l2_port_arbiter: directed scenarios plus randomized traffic against a queue-free reference model.
// A behavioural SRAM stands in for the memory wrapper.
`timescale 1ns/1ps
module tb_l2_port_arbiter;

    localparam int NP    = 4;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic            CLK = 1'b0;
    logic            RSTN;
    logic [NP-1:0]   req, wen;
    logic [AW-1:0]   addr_p  [NP];
    logic [63:0]     wdata_p [NP];
    logic [7:0]      be_p    [NP];
    logic [NP*AW-1:0] addr_bus;
    logic [NP*64-1:0] wdata_bus;
    logic [NP*8-1:0]  be_bus;

    logic [NP-1:0]   gnt_o, r_valid_o;
    logic [63:0]     r_rdata_o, mem_d_o, mem_q;
    logic            init_done_o, mem_cen_o, mem_wen_o;
    logic [AW-1:0]   mem_a_o;
    logic [7:0]      mem_be_o;

    logic [63:0]     sram    [DEPTH];
    logic [63:0]     ref_mem [DEPTH];
    int              ptr_m;
    int              n_vec = 0;
    int              n_err = 0;

    always #5 CLK = ~CLK;

    always_comb begin
        for (int p = 0; p < NP; p++) begin
            addr_bus[p*AW +: AW]  = addr_p[p];
            wdata_bus[p*64 +: 64] = wdata_p[p];
            be_bus[p*8 +: 8]      = be_p[p];
        end
    end

    l2_port_arbiter #(
        .N_PORTS        (NP),
        .MEM_ADDR_WIDTH (AW),
        .INIT_ON_RESET  (1'b1)
    ) dut (
        .CLK         (CLK),
        .RSTN        (RSTN),
        .req_i       (req),
        .gnt_o       (gnt_o),
        .wen_i       (wen),
        .addr_i      (addr_bus),
        .wdata_i     (wdata_bus),
        .be_i        (be_bus),
        .r_valid_o   (r_valid_o),
        .r_rdata_o   (r_rdata_o),
        .init_done_o (init_done_o),
        .mem_cen_o   (mem_cen_o),
        .mem_wen_o   (mem_wen_o),
        .mem_a_o     (mem_a_o),
        .mem_d_o     (mem_d_o),
        .mem_be_o    (mem_be_o),
        .mem_q_i     (mem_q)
    );

    function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] d, input logic [7:0] be);
        logic [63:0] r;
        r = old;
        for (int b = 0; b < 8; b++) if (be[b]) r[b*8 +: 8] = d[b*8 +: 8];
        return r;
    endfunction

    // Memory holds garbage while in reset so the sweep has something to overwrite.
    always @(posedge CLK) begin
        if (!RSTN) begin
            for (int i = 0; i < DEPTH; i++) sram[i] <= {$urandom(), $urandom()};
        end else if (!mem_cen_o) begin
            if (!mem_wen_o) sram[mem_a_o] <= merge(sram[mem_a_o], mem_d_o, mem_be_o);
            else            mem_q <= sram[mem_a_o];
        end
    end

    // Reference arbitration: first requester scanning upward from the pointer, modulo NP.
    function automatic int pick(input logic [NP-1:0] r, input int p);
        for (int k = 0; k < NP; k++) if (r[(p + k) % NP]) return (p + k) % NP;
        return -1;
    endfunction

    task automatic set_port(input int p, input logic w, input logic [AW-1:0] a,
                            input logic [63:0] d, input logic [7:0] b);
        wen[p] = w; addr_p[p] = a; wdata_p[p] = d; be_p[p] = b;
    endtask

    task automatic test_reset;
        RSTN = 1'b0; req = '0; wen = '1;
        for (int p = 0; p < NP; p++) set_port(p, 1'b1, '0, '0, '0);
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        n_vec++; if (gnt_o !== 4'b0000) begin n_err++; $display("FAIL reset_gnt got %b want 0000", gnt_o); end
        n_vec++; if ({mem_cen_o, mem_wen_o} !== 2'b11) begin n_err++; $display("FAIL reset_mem_ctl got %b want 11", {mem_cen_o, mem_wen_o}); end
        n_vec++; if (r_valid_o !== 4'b0000) begin n_err++; $display("FAIL reset_rvalid got %b want 0000", r_valid_o); end
        n_vec++; if (init_done_o !== 1'b0) begin n_err++; $display("FAIL reset_init_done got %b want 0", init_done_o); end
    endtask

    // Shared by the power-on sweep and the post-reset restart; req_i=F stays pending throughout.
    task automatic run_sweep(input string tag);
        for (int p = 0; p < NP; p++) set_port(p, 1'b1, '0, '0, '0);
        req = '1;
        @(posedge CLK); #1 RSTN = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge CLK);
            n_vec++;
            if (gnt_o !== 4'b0000 || init_done_o !== 1'b0) begin
                n_err++; $display("FAIL %s_gnt cyc %0d got gnt=%b done=%b want 0000/0", tag, i, gnt_o, init_done_o);
            end
            n_vec++;
            if ({mem_cen_o, mem_wen_o, mem_a_o, mem_d_o, mem_be_o} !== {1'b0, 1'b0, AW'(i), 64'd0, 8'hFF}) begin
                n_err++; $display("FAIL %s_write cyc %0d got cen=%b wen=%b a=%0d d=%h be=%h want 0/0/%0d/0/ff",
                                  tag, i, mem_cen_o, mem_wen_o, mem_a_o, mem_d_o, mem_be_o, i);
            end
            @(posedge CLK);
        end
        @(negedge CLK);
        n_vec++; if (init_done_o !== 1'b1) begin n_err++; $display("FAIL %s_done got %b want 1", tag, init_done_o); end
        n_vec++; if (gnt_o !== 4'b0001) begin n_err++; $display("FAIL %s_first_gnt got %b want 0001", tag, gnt_o); end
        @(posedge CLK); #1 req = '0;
        @(negedge CLK);
        n_vec++; if (r_valid_o !== 4'b0001) begin n_err++; $display("FAIL %s_first_rvalid got %b want 0001", tag, r_valid_o); end
        n_vec++; if (r_rdata_o !== 64'd0) begin n_err++; $display("FAIL %s_first_rdata got %h want 0", tag, r_rdata_o); end
    endtask

    task automatic test_init_sweep;
        run_sweep("sweep");
        for (int i = 0; i < DEPTH; i++) begin
            n_vec++; if (sram[i] !== 64'd0) begin n_err++; $display("FAIL sweep_zero addr %0d got %h want 0", i, sram[i]); end
        end
    endtask

    task automatic test_write_read;
        @(posedge CLK); #1;
        set_port(1, 1'b0, 4'd5, 64'hDEAD_BEEF_0123_4567, 8'hFF); req = 4'b0010;
        @(negedge CLK);
        n_vec++; if (gnt_o !== 4'b0010) begin n_err++; $display("FAIL wr_gnt got %b want 0010", gnt_o); end
        n_vec++;
        if ({mem_wen_o, mem_a_o, mem_d_o} !== {1'b0, 4'd5, 64'hDEAD_BEEF_0123_4567}) begin
            n_err++; $display("FAIL wr_mem got wen=%b a=%0d d=%h want 0/5/deadbeef01234567", mem_wen_o, mem_a_o, mem_d_o);
        end
        @(posedge CLK); #1;
        set_port(2, 1'b1, 4'd5, '0, '0); req = 4'b0100;
        @(negedge CLK);
        n_vec++; if (gnt_o !== 4'b0100) begin n_err++; $display("FAIL rd_gnt got %b want 0100", gnt_o); end
        n_vec++; if (r_valid_o !== 4'b0010) begin n_err++; $display("FAIL wr_ack got %b want 0010", r_valid_o); end
        @(posedge CLK); #1 req = '0;
        @(negedge CLK);
        n_vec++; if (r_valid_o !== 4'b0100) begin n_err++; $display("FAIL rd_rvalid got %b want 0100", r_valid_o); end
        n_vec++; if (r_rdata_o !== 64'hDEAD_BEEF_0123_4567) begin n_err++; $display("FAIL rd_rdata got %h want deadbeef01234567", r_rdata_o); end
    endtask

    task automatic test_byte_enable;
        @(posedge CLK); #1;
        set_port(0, 1'b0, 4'd9, '1, 8'h0F); req = 4'b0001;
        @(negedge CLK);
        n_vec++; if (gnt_o !== 4'b0001) begin n_err++; $display("FAIL be_wr_gnt got %b want 0001", gnt_o); end
        @(posedge CLK); #1;
        set_port(0, 1'b1, 4'd9, '0, '0);
        @(negedge CLK);
        n_vec++; if (gnt_o !== 4'b0001) begin n_err++; $display("FAIL be_rd_gnt got %b want 0001", gnt_o); end
        @(posedge CLK); #1 req = '0;
        @(negedge CLK);
        n_vec++; if (r_rdata_o !== 64'h0000_0000_FFFF_FFFF) begin n_err++; $display("FAIL be_rdata got %h want 00000000ffffffff", r_rdata_o); end
    endtask

    task automatic test_round_robin;
        logic [NP-1:0] exp_g, exp_v;
        // A lone port-3 grant moves the pointer back to 0.
        @(posedge CLK); #1;
        set_port(3, 1'b1, 4'd3, '0, '0); req = 4'b1000;
        @(negedge CLK);
        n_vec++; if (gnt_o !== 4'b1000) begin n_err++; $display("FAIL rr_align_gnt got %b want 1000", gnt_o); end
        for (int c = 0; c < 2 * NP; c++) begin
            @(posedge CLK); #1;
            for (int p = 0; p < NP; p++) set_port(p, 1'b1, AW'(p), '0, '0);
            req = '1;
            @(negedge CLK);
            exp_g = NP'(1 << (c % NP));
            exp_v = (c == 0) ? 4'b1000 : NP'(1 << ((c - 1) % NP));
            n_vec++; if (gnt_o !== exp_g) begin n_err++; $display("FAIL rr_gnt cyc %0d got %b want %b", c, gnt_o, exp_g); end
            n_vec++; if (r_valid_o !== exp_v) begin n_err++; $display("FAIL rr_rvalid cyc %0d got %b want %b", c, r_valid_o, exp_v); end
        end
        @(posedge CLK); #1 req = '0;
        @(negedge CLK);
        n_vec++; if (r_valid_o !== 4'b1000) begin n_err++; $display("FAIL rr_last_rvalid got %b want 1000", r_valid_o); end
    endtask

    task automatic test_wrap;
        @(posedge CLK); #1;
        set_port(3, 1'b1, 4'd1, '0, '0); req = 4'b1000;
        @(negedge CLK);
        n_vec++; if (gnt_o !== 4'b1000) begin n_err++; $display("FAIL wrap_p3_gnt got %b want 1000", gnt_o); end
        @(posedge CLK); #1;
        set_port(0, 1'b1, 4'd2, '0, '0); set_port(3, 1'b1, 4'd4, '0, '0); req = 4'b1001;
        @(negedge CLK);
        n_vec++; if (gnt_o !== 4'b0001) begin n_err++; $display("FAIL wrap_p0_gnt got %b want 0001", gnt_o); end
        @(posedge CLK); #1 req = 4'b1000;
        @(negedge CLK);
        n_vec++; if (gnt_o !== 4'b1000) begin n_err++; $display("FAIL wrap_p3_again got %b want 1000", gnt_o); end
        n_vec++; if (r_valid_o !== 4'b0001) begin n_err++; $display("FAIL wrap_rvalid got %b want 0001", r_valid_o); end
        @(posedge CLK); #1 req = '0;
        @(negedge CLK);
    endtask

    task automatic test_random_traffic;
        int            w, pend, last_w;
        logic          pend_rd;
        logic [63:0]   pend_dat;
        logic [NP-1:0] exp_g, exp_v;
        ptr_m = 0; pend = -1; last_w = -1; pend_rd = 1'b0; pend_dat = '0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        ref_mem[5] = 64'hDEAD_BEEF_0123_4567;
        ref_mem[9] = 64'h0000_0000_FFFF_FFFF;
        for (int c = 0; c < 300; c++) begin
            @(posedge CLK); #1;
            if (last_w >= 0) req[last_w] = 1'b0;
            for (int p = 0; p < NP; p++) begin
                if (!req[p] && $urandom_range(0, 2) != 0) begin
                    set_port(p, 1'($urandom_range(0, 1)), AW'($urandom_range(0, DEPTH - 1)),
                             {$urandom(), $urandom()}, 8'($urandom_range(0, 255)));
                    req[p] = 1'b1;
                end
            end
            @(negedge CLK);
            w     = pick(req, ptr_m);
            exp_g = (w < 0) ? '0 : NP'(1 << w);
            exp_v = (pend < 0) ? '0 : NP'(1 << pend);
            n_vec++; if (gnt_o !== exp_g) begin n_err++; $display("FAIL rnd_gnt cyc %0d got %b want %b", c, gnt_o, exp_g); end
            n_vec++; if (r_valid_o !== exp_v) begin n_err++; $display("FAIL rnd_rvalid cyc %0d got %b want %b", c, r_valid_o, exp_v); end
            if (pend >= 0 && pend_rd) begin
                n_vec++; if (r_rdata_o !== pend_dat) begin n_err++; $display("FAIL rnd_rdata cyc %0d got %h want %h", c, r_rdata_o, pend_dat); end
            end
            if (w >= 0) begin
                n_vec++;
                if ({mem_cen_o, mem_wen_o, mem_a_o, mem_d_o, mem_be_o} !== {1'b0, wen[w], addr_p[w], wdata_p[w], be_p[w]}) begin
                    n_err++; $display("FAIL rnd_mem cyc %0d got wen=%b a=%0d d=%h be=%h want %b/%0d/%h/%h", c,
                                      mem_wen_o, mem_a_o, mem_d_o, mem_be_o, wen[w], addr_p[w], wdata_p[w], be_p[w]);
                end
                pend_rd = wen[w];
                if (wen[w]) pend_dat = ref_mem[addr_p[w]];
                else        ref_mem[addr_p[w]] = merge(ref_mem[addr_p[w]], wdata_p[w], be_p[w]);
                ptr_m = (w + 1) % NP;
            end else if (mem_cen_o !== 1'b1) begin
                n_vec++; n_err++; $display("FAIL rnd_idle_cen cyc %0d got %b want 1", c, mem_cen_o);
            end
            pend   = w;
            last_w = w;
        end
        @(posedge CLK); #1 req = '0;
        @(negedge CLK);
        exp_v = (pend < 0) ? '0 : NP'(1 << pend);
        n_vec++; if (r_valid_o !== exp_v) begin n_err++; $display("FAIL rnd_tail_rvalid got %b want %b", r_valid_o, exp_v); end
        if (pend >= 0 && pend_rd) begin
            n_vec++; if (r_rdata_o !== pend_dat) begin n_err++; $display("FAIL rnd_tail_rdata got %h want %h", r_rdata_o, pend_dat); end
        end
    endtask

    task automatic test_mid_reset;
        @(posedge CLK); #1;
        set_port(2, 1'b1, 4'd5, '0, '0); req = 4'b0100;
        @(negedge CLK);
        n_vec++; if (gnt_o !== 4'b0100) begin n_err++; $display("FAIL mrst_gnt got %b want 0100", gnt_o); end
        #1 RSTN = 1'b0;
        @(posedge CLK); #1 req = '1;
        @(negedge CLK);
        n_vec++; if (r_valid_o !== 4'b0000) begin n_err++; $display("FAIL mrst_rvalid got %b want 0000", r_valid_o); end
        n_vec++; if (gnt_o !== 4'b0000) begin n_err++; $display("FAIL mrst_gnt_in_rst got %b want 0000", gnt_o); end
        n_vec++; if ({mem_cen_o, mem_wen_o, init_done_o} !== 3'b110) begin
            n_err++; $display("FAIL mrst_ctl got cen/wen/done=%b want 110", {mem_cen_o, mem_wen_o, init_done_o});
        end
        run_sweep("resweep");
    endtask

    initial begin
        test_reset();
        test_init_sweep();
        test_write_read();
        test_byte_enable();
        test_round_robin();
        test_wrap();
        test_random_traffic();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
